// File: rtl/counter_led_pkg.sv
// Shared constants for the LED blink counter.
package counter_led_pkg;

  localparam int unsigned CNT_MAX_DEFAULT  = 49;
  localparam logic        LED_INIT_DEFAULT = 1'b0;
  localparam int unsigned SYS_CLK_HZ       = 50_000_000;

endpackage

// File: rtl/mod_counter.sv
// Free-running modulo-(MAX+1) counter with a combinational wrap flag.
module mod_counter #(
  parameter int unsigned MAX = 49,
  parameter int unsigned W   = 6
) (
  input  logic         clk,
  input  logic         rst,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_cnt_next;

  // Flag the terminal count so the parent can toggle on the same edge.
  always_comb begin
    wrap       = (r_cnt == W'(MAX));
    w_cnt_next = wrap ? '0 : r_cnt + W'(1);
  end

  // Count state; synchronous reset restarts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/counter_led_blink.sv
// LED blinker: toggles led_out each time a modulo-(CNT_MAX+1) counter wraps.
// Optional feature macro: COUNTER_LED_TICK_EN adds the registered cnt_tick output.
module counter_led_blink
  import counter_led_pkg::*;
#(
  parameter int unsigned CNT_MAX  = CNT_MAX_DEFAULT,
  parameter int unsigned CNT_W    = $clog2(CNT_MAX + 1),
  parameter logic        LED_INIT = LED_INIT_DEFAULT
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  output logic             led_out,
  output logic [CNT_W-1:0] cnt
`ifdef COUNTER_LED_TICK_EN
  ,
  output logic             cnt_tick
`endif
);

  logic w_wrap;
  logic r_led;

  mod_counter #(
    .MAX (CNT_MAX),
    .W   (CNT_W)
  ) u_mod_counter (
    .clk  (sys_clk),
    .rst  (sys_rst),
    .cnt  (cnt),
    .wrap (w_wrap)
  );

  // LED flips on every wrap; reset wins over a coincident wrap.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_led <= LED_INIT;
    end else if (w_wrap) begin
      r_led <= ~r_led;
    end
  end

  assign led_out = r_led;

`ifdef COUNTER_LED_TICK_EN
  logic r_tick;

  // One-cycle pulse aligned with the cycle where cnt returns to zero.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_wrap;
    end
  end

  assign cnt_tick = r_tick;
`endif

endmodule

// File: tb/tb_counter_led_blink.sv
// Self-checking bench for counter_led_blink: default and CNT_MAX=1 instances
// compared against an edge-count reference model.
module tb_counter_led_blink;

  localparam int unsigned M0 = 49;
  localparam int unsigned M1 = 1;
  localparam logic        LI = 1'b0;

  logic       sys_clk;
  logic       sys_rst;
  logic       led0, led1;
  logic [5:0] cnt0;
  logic [0:0] cnt1;
`ifdef COUNTER_LED_TICK_EN
  logic       tick0, tick1;
`endif

  counter_led_blink u_dut0 (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .led_out  (led0),
    .cnt      (cnt0)
`ifdef COUNTER_LED_TICK_EN
    ,
    .cnt_tick (tick0)
`endif
  );

  counter_led_blink #(
    .CNT_MAX (M1)
  ) u_dut1 (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .led_out  (led1),
    .cnt      (cnt1)
`ifdef COUNTER_LED_TICK_EN
    ,
    .cnt_tick (tick1)
`endif
  );

  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_pass   = 0;
  // Edges since the last edge that sampled reset high.
  int n0 = 0;
  int n1 = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int exp_cnt(input int n, input int unsigned m);
    return n % (m + 1);
  endfunction

  function automatic logic exp_led(input int n, input int unsigned m);
    return LI ^ logic'((n / (m + 1)) % 2);
  endfunction

  function automatic logic exp_tick(input int n, input int unsigned m);
    return (n != 0) && (n % (m + 1) == 0);
  endfunction

  task automatic compare_all();
    check_eq("cnt0", 32'(cnt0), 32'(exp_cnt(n0, M0)));
    check_eq("led0", 32'(led0), 32'(exp_led(n0, M0)));
    check_eq("cnt1", 32'(cnt1), 32'(exp_cnt(n1, M1)));
    check_eq("led1", 32'(led1), 32'(exp_led(n1, M1)));
`ifdef COUNTER_LED_TICK_EN
    check_eq("tick0", 32'(tick0), 32'(exp_tick(n0, M0)));
    check_eq("tick1", 32'(tick1), 32'(exp_tick(n1, M1)));
`endif
  endtask

  // Called just after a falling edge; drives reset, advances one rising edge,
  // updates the model and samples on the next falling edge.
  task automatic step(input logic r, input logic glitch);
    sys_rst = r;
    if (glitch && !r) begin
      #2 sys_rst = 1'b1;
      #2 sys_rst = 1'b0;
    end
    @(posedge sys_clk);
    if (r) begin
      n0 = 0;
      n1 = 0;
    end else begin
      n0++;
      n1++;
    end
    @(negedge sys_clk);
    compare_all();
  endtask

  initial begin
    int toggles;
    int max_cnt;
    int ticks;
    logic prev_led;
    int len;

    sys_rst = 1'b1;
    @(negedge sys_clk);

    // Reset state.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);

    // Free run after release: toggles, max count, tick count.
    toggles  = 0;
    max_cnt  = 0;
    ticks    = 0;
    prev_led = led0;
    for (int i = 0; i < 5000; i++) begin
      step(1'b0, 1'b0);
      if (i < 200 && led0 !== prev_led) toggles++;
      prev_led = led0;
      if (int'(cnt0) > max_cnt) max_cnt = int'(cnt0);
`ifdef COUNTER_LED_TICK_EN
      if (tick0 === 1'b1) ticks++;
`endif
    end
    check_eq("toggles_4000ns", 32'(toggles), 32'd4);
    check_eq("cnt_max_seen", 32'(max_cnt), 32'(M0));
`ifdef COUNTER_LED_TICK_EN
    check_eq("tick_count_5000", 32'(ticks), 32'd100);
`endif

    // Long reset mid-count with led high.
    for (int i = 0; i < 200; i++) begin
      if (exp_led(n0, M0) == 1'b1 && exp_cnt(n0, M0) == 20) break;
      step(1'b0, 1'b0);
    end
    check_eq("pre_rst_led_high", 32'(led0), 32'd1);
    for (int i = 0; i < 250; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 120; i++) step(1'b0, 1'b0);

    // Reset on the edge where cnt == CNT_MAX.
    for (int i = 0; i < 100; i++) begin
      if (exp_cnt(n0, M0) == int'(M0)) break;
      step(1'b0, 1'b0);
    end
    check_eq("pre_rst_cnt_max", 32'(cnt0), 32'(M0));
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // Randomized reset bursts and sub-cycle reset glitches.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        len = int'($urandom_range(1, 8));
        for (int j = 0; j < len; j++) step(1'b1, 1'b0);
      end else begin
        step(1'b0, logic'($urandom_range(0, 99) < 3));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
